// File: rtl/dsp48_pkg.sv
// dsp48_pkg: shared widths, operand-select and ALU encodings for the DSP48 slice
package dsp48_pkg;
  localparam int A_W      = 30;
  localparam int B_W      = 18;
  localparam int P_W      = 48;
  localparam int MULT_A_W = 25;
  localparam int SHIFT    = 17;
  typedef enum logic [1:0] {X_ZERO = 2'b00, X_M = 2'b01, X_P = 2'b10, X_AB = 2'b11} x_sel_e;
  typedef enum logic [1:0] {Y_ZERO = 2'b00, Y_M = 2'b01, Y_ONES = 2'b10, Y_C = 2'b11} y_sel_e;
  typedef enum logic [2:0] {
    Z_ZERO   = 3'b000,
    Z_PCIN   = 3'b001,
    Z_P      = 3'b010,
    Z_C      = 3'b011,
    Z_PCIN17 = 3'b101,
    Z_P17    = 3'b110
  } z_sel_e;
  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_NZ_ADD  = 4'b0001,
    ALU_NOT_SUM = 4'b0010,
    ALU_SUB     = 4'b0011
  } alu_e;
endpackage

// File: rtl/dsp48_slice_if.sv
// dsp48_slice_if: operand, control and result bundle of the DSP48 slice
interface dsp48_slice_if;
  import dsp48_pkg::*;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [P_W-1:0] c;
  logic [P_W-1:0] pcin;
  logic           carryin;
  logic [6:0]     opmode;
  logic [3:0]     alumode;
  logic           cea, ceb, cec, cem, cep;
  logic [P_W-1:0] p;
  logic [P_W-1:0] pcout;
  logic [A_W-1:0] acout;
  logic [B_W-1:0] bcout;
  logic [3:0]     carryout;
  logic           carrycascout;
  logic           multsignout;
  logic           patterndetect, patternbdetect;
  modport master (
    output a, b, c, pcin, carryin, opmode, alumode, cea, ceb, cec, cem, cep,
    input  p, pcout, acout, bcout, carryout, carrycascout, multsignout, patterndetect, patternbdetect
  );
  modport slave (
    input  a, b, c, pcin, carryin, opmode, alumode, cea, ceb, cec, cem, cep,
    output p, pcout, acout, bcout, carryout, carrycascout, multsignout, patterndetect, patternbdetect
  );
endinterface

// File: rtl/dsp48_mult25x18.sv
// dsp48_mult25x18: signed 25x18 multiplier, sign-extended to 48 bits, optional MREG stage
module dsp48_mult25x18
  import dsp48_pkg::*;
#(
  parameter int MREG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ce,
  input  logic [MULT_A_W-1:0] i_a,
  input  logic [B_W-1:0]      i_b,
  output logic [P_W-1:0]      o_m
);
  logic [P_W-1:0] w_prod;
  logic [P_W-1:0] r_m;
  assign w_prod = 48'($signed(i_a)) * 48'($signed(i_b));
  // product register; bypassed below when MREG is 0
  always_ff @(posedge clk) begin
    if (rst) r_m <= '0;
    else if (i_ce) r_m <= w_prod;
  end
  assign o_m = (MREG == 1) ? r_m : w_prod;
endmodule

// File: rtl/dsp48_slice.sv
// dsp48_slice: 25x18 MAC slice (DSP48E1 ONE48 subset); define DSP48_PATDET_EN for pattern detect
module dsp48_slice
  import dsp48_pkg::*;
#(
  parameter int AREG = 0,
  parameter int BREG = 0,
  parameter int CREG = 1,
  parameter int MREG = 0,
  parameter int PREG = 0
`ifdef DSP48_PATDET_EN
  ,
  parameter logic [P_W-1:0] PATTERN = 48'h0,
  parameter logic [P_W-1:0] MASK    = 48'h3FFF_FFFF_FFFF
`endif
) (
  input logic          clk,
  input logic          rst,
  dsp48_slice_if.slave bus
);
  logic [A_W-1:0] r_a, w_a;
  logic [B_W-1:0] r_b, w_b;
  logic [P_W-1:0] r_c, w_c;
  logic [P_W-1:0] w_m, r_p, w_pfb, w_pfb_sh, w_pcin_sh;
  logic [P_W-1:0] w_x, w_y, w_z, w_res;
  logic [P_W:0]   w_s, w_sum;
  logic           w_co, r_co, w_inv;
  // input pipeline stages; each is bypassed below when its parameter is 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else begin
      if (bus.cea) r_a <= bus.a;
      if (bus.ceb) r_b <= bus.b;
      if (bus.cec) r_c <= bus.c;
    end
  end
  assign w_a = (AREG == 1) ? r_a : bus.a;
  assign w_b = (BREG == 1) ? r_b : bus.b;
  assign w_c = (CREG == 1) ? r_c : bus.c;
  dsp48_mult25x18 #(.MREG(MREG)) u_mult (
    .clk  (clk),
    .rst  (rst),
    .i_ce (bus.cem),
    .i_a  (w_a[MULT_A_W-1:0]),
    .i_b  (w_b),
    .o_m  (w_m)
  );
  assign w_pfb     = (PREG == 1) ? r_p : '0;
  assign w_pfb_sh  = $signed(w_pfb) >>> SHIFT;
  assign w_pcin_sh = $signed(bus.pcin) >>> SHIFT;
  // operand muxes and ALU; M only contributes when both X and Y select it
  always_comb begin
    w_x = (bus.opmode[1:0] == X_M)  ? ((bus.opmode[3:2] == Y_M) ? w_m : '0) :
          (bus.opmode[1:0] == X_P)  ? w_pfb :
          (bus.opmode[1:0] == X_AB) ? {w_a, w_b} : '0;
    w_y = (bus.opmode[3:2] == Y_ONES) ? '1 :
          (bus.opmode[3:2] == Y_C)    ? w_c : '0;
    w_z = (bus.opmode[6:4] == Z_PCIN)   ? bus.pcin :
          (bus.opmode[6:4] == Z_P)      ? w_pfb :
          (bus.opmode[6:4] == Z_C)      ? w_c :
          (bus.opmode[6:4] == Z_PCIN17) ? w_pcin_sh :
          (bus.opmode[6:4] == Z_P17)    ? w_pfb_sh : '0;
    w_s   = {1'b0, w_x} + {1'b0, w_y} + {{P_W{1'b0}}, bus.carryin};
    w_sum = (bus.alumode == ALU_SUB)    ? {1'b0, w_z} - w_s :
            (bus.alumode == ALU_NZ_ADD) ? {1'b0, ~w_z} + w_s : {1'b0, w_z} + w_s;
    w_inv = (bus.alumode == ALU_SUB) || (bus.alumode == ALU_NOT_SUM);
    w_res = (bus.alumode == ALU_NOT_SUM) ? ~w_sum[P_W-1:0] : w_sum[P_W-1:0];
    w_co  = w_sum[P_W] ^ w_inv;
  end
  // output register for result and carry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p  <= '0;
      r_co <= 1'b0;
    end else if (bus.cep) begin
      r_p  <= w_res;
      r_co <= w_co;
    end
  end
  assign bus.p            = (PREG == 1) ? r_p : w_res;
  assign bus.pcout        = bus.p;
  assign bus.carryout     = {(PREG == 1) ? r_co : w_co, 3'b000};
  assign bus.carrycascout = bus.carryout[3];
  assign bus.acout        = w_a;
  assign bus.bcout        = w_b;
  assign bus.multsignout  = w_m[P_W-1];
`ifdef DSP48_PATDET_EN
  logic w_pd, w_pbd, r_pd, r_pbd;
  assign w_pd  = ((w_res ^ PATTERN) & ~MASK) == '0;
  assign w_pbd = ((w_res ^ ~PATTERN) & ~MASK) == '0;
  // detect flags follow the P register timing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pd  <= 1'b0;
      r_pbd <= 1'b0;
    end else if (bus.cep) begin
      r_pd  <= w_pd;
      r_pbd <= w_pbd;
    end
  end
  assign bus.patterndetect  = (PREG == 1) ? r_pd : w_pd;
  assign bus.patternbdetect = (PREG == 1) ? r_pbd : w_pbd;
`else
  assign bus.patterndetect  = 1'b0;
  assign bus.patternbdetect = 1'b0;
`endif
endmodule

// File: tb/tb_dsp48_slice.sv
// tb_dsp48_slice: vector table on a combinational slice, accumulate/reset on PREG=1, pipelined scoreboard
module tb_dsp48_slice;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_tot = 0;
  always #5 clk = ~clk;
  dsp48_slice_if bus0 ();
  dsp48_slice_if bus1 ();
  dsp48_slice_if bus2 ();
  dsp48_slice #(.AREG(0), .BREG(0), .CREG(0), .MREG(0), .PREG(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  dsp48_slice #(.AREG(0), .BREG(0), .CREG(0), .MREG(0), .PREG(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  dsp48_slice #(.AREG(1), .BREG(1), .CREG(1), .MREG(1), .PREG(1)) u2 (.clk(clk), .rst(rst), .bus(bus2));
  typedef struct {
    logic [29:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [47:0] pcin;
    logic        cin;
    logic [6:0]  op;
    logic [3:0]  alu;
    logic [47:0] p;
    logic        co;
    logic        ms;
    string       nm;
  } vec_t;
  vec_t vecs[$];
  logic [47:0] sb_q[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus0.a = '0; bus0.b = '0; bus0.c = '0; bus0.pcin = '0; bus0.carryin = 1'b0;
    bus0.opmode = '0; bus0.alumode = '0;
    bus0.cea = 1'b1; bus0.ceb = 1'b1; bus0.cec = 1'b1; bus0.cem = 1'b1; bus0.cep = 1'b1;
    bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.pcin = '0; bus1.carryin = 1'b0;
    bus1.opmode = '0; bus1.alumode = '0;
    bus1.cea = 1'b1; bus1.ceb = 1'b1; bus1.cec = 1'b1; bus1.cem = 1'b1; bus1.cep = 1'b1;
    bus2.a = 30'h3FFF_FFFF; bus2.b = 18'h3FFFF; bus2.c = '1; bus2.pcin = '0; bus2.carryin = 1'b0;
    bus2.opmode = 7'b0000101; bus2.alumode = '0;
    bus2.cea = 1'b1; bus2.ceb = 1'b1; bus2.cec = 1'b1; bus2.cem = 1'b1; bus2.cep = 1'b1;
    vecs.push_back('{30'd100, 18'd200, 48'd0, 48'd0, 1'b0, 7'b0000101, 4'b0000, 48'd20000, 1'b0, 1'b0, "mul_pos"});
    vecs.push_back('{-30'sd100, 18'd200, 48'd0, 48'd0, 1'b0, 7'b0000101, 4'b0000, 48'hFFFF_FFFF_B1E0, 1'b0, 1'b1, "mul_neg"});
    vecs.push_back('{30'd100, 18'd200, 48'd400, 48'd0, 1'b0, 7'b0110101, 4'b0000, 48'd20400, 1'b0, 1'b0, "c_plus_m"});
    vecs.push_back('{30'd100, 18'd200, 48'd400, 48'd0, 1'b0, 7'b0110101, 4'b0011, 48'hFFFF_FFFF_B370, 1'b0, 1'b0, "c_minus_m"});
    vecs.push_back('{30'd1, 18'd2, 48'd0, 48'd0, 1'b0, 7'b0000011, 4'b0000, 48'd262146, 1'b0, 1'b0, "ab_concat"});
    vecs.push_back('{30'd1, 18'd2, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b1, 7'b0110000, 4'b0000, 48'd0, 1'b1, 1'b0, "c_wrap_carry"});
    vecs.push_back('{30'd0, 18'd0, 48'd0, 48'h8000_0000_0000, 1'b0, 7'b1010000, 4'b0000, 48'hFFFF_C000_0000, 1'b0, 1'b0, "pcin_shift"});
    vecs.push_back('{30'd0, 18'd0, 48'd0, 48'd5, 1'b1, 7'b0010000, 4'b0001, 48'hFFFF_FFFF_FFFB, 1'b0, 1'b0, "not_z_add"});
    vecs.push_back('{30'd0, 18'd0, 48'd0, 48'd5, 1'b0, 7'b0010000, 4'b0010, 48'hFFFF_FFFF_FFFA, 1'b1, 1'b0, "not_sum"});
    vecs.push_back('{30'd100, 18'd200, 48'd0, 48'd0, 1'b0, 7'b0000001, 4'b0000, 48'd0, 1'b0, 1'b0, "illegal_xm"});
    vecs.push_back('{30'd0, 18'd0, 48'd0, 48'd0, 1'b1, 7'b0001000, 4'b0000, 48'd0, 1'b1, 1'b0, "ones_wrap"});
    vecs.push_back('{30'd9, 18'd9, 48'd7, 48'd3, 1'b0, 7'b1101110, 4'b0000, 48'd7, 1'b0, 1'b0, "p_sel_no_preg"});
    vecs.push_back('{30'd3, 18'd5, 48'd0, 48'd0, 1'b0, 7'b0000101, 4'b0101, 48'd15, 1'b0, 1'b0, "alu_other"});
    vecs.push_back('{30'h100_0000, 18'h20000, 48'd0, 48'd0, 1'b0, 7'b0000101, 4'b0000, 48'h0200_0000_0000, 1'b0, 1'b0, "mul_min"});
    vecs.push_back('{30'd0, 18'd0, 48'd500, 48'd0, 1'b0, 7'b0111100, 4'b0011, 48'd0, 1'b1, 1'b0, "sub_no_borrow"});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_preg", 64'(bus1.p), 64'd0);
    chk("rst_p_pipe", 64'(bus2.p), 64'd0);
    chk("rst_acout_pipe", 64'(bus2.acout), 64'd0);
    chk("rst_bcout_pipe", 64'(bus2.bcout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus2.a = '0; bus2.b = '0; bus2.c = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus0.a = vecs[i].a; bus0.b = vecs[i].b; bus0.c = vecs[i].c; bus0.pcin = vecs[i].pcin;
      bus0.carryin = vecs[i].cin; bus0.opmode = vecs[i].op; bus0.alumode = vecs[i].alu;
      #1;
      chk({vecs[i].nm, "_p"}, 64'(bus0.p), 64'(vecs[i].p));
      chk({vecs[i].nm, "_pcout"}, 64'(bus0.pcout), 64'(vecs[i].p));
      chk({vecs[i].nm, "_carryout"}, 64'(bus0.carryout), 64'({vecs[i].co, 3'b000}));
      chk({vecs[i].nm, "_cascout"}, 64'(bus0.carrycascout), 64'(vecs[i].co));
      chk({vecs[i].nm, "_multsign"}, 64'(bus0.multsignout), 64'(vecs[i].ms));
      chk({vecs[i].nm, "_acout"}, 64'(bus0.acout), 64'(vecs[i].a));
      chk({vecs[i].nm, "_patdet"}, 64'({bus0.patterndetect, bus0.patternbdetect}), 64'd0);
    end
    begin
      logic        seq_rst[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        seq_cep[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [47:0] seq_exp[7] = '{48'd15, 48'd30, 48'd45, 48'd45, 48'd0, 48'd15, 48'd30};
      @(negedge clk);
      bus1.a = 30'd3; bus1.b = 18'd5; bus1.opmode = 7'b0100101; bus1.alumode = 4'b0000;
      for (int i = 0; i < 7; i++) begin
        rst = seq_rst[i];
        bus1.cep = seq_cep[i];
        @(posedge clk);
        #1;
        chk($sformatf("accum_step%0d", i), 64'(bus1.p), 64'(seq_exp[i]));
        @(negedge clk);
      end
      rst = 1'b0;
      bus1.cep = 1'b1;
    end
    begin
      logic [24:0] ra;
      logic [17:0] rb;
      logic [29:0] drv_a;
      longint      pa, pb, pr;
      logic [63:0] pw;
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        if (i < 12) begin
          ra = (i == 0) ? 25'h100_0000 : (i == 1) ? 25'h0FF_FFFF : 25'($urandom);
          rb = (i == 0) ? 18'h20000 : (i == 1) ? 18'h1FFFF : 18'($urandom);
          drv_a = {5'($urandom), ra};
          bus2.a = drv_a;
          bus2.b = rb;
          pa = longint'($signed(ra));
          pb = longint'($signed(rb));
          pr = pa * pb;
          pw = 64'(pr);
          sb_q.push_back(pw[47:0]);
        end
        @(posedge clk);
        #1;
        if (i < 12) chk($sformatf("pipe_acout%0d", i), 64'(bus2.acout), 64'(drv_a));
        if (i >= 2) begin
          if (sb_q.size() == 0) begin
            n_tot++;
            $display("FAIL pipe_p%0d: got %0h want queued result (queue empty)", i, bus2.p);
          end else chk($sformatf("pipe_p%0d", i), 64'(bus2.p), 64'(sb_q.pop_front()));
        end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
